// File: rtl/frame_renderer_pkg.sv
// Shared constants for the frame renderer: game-state encodings, object
// geometry, score-overlay placement and palette.
package frame_renderer_pkg;

  typedef enum logic [1:0] {
    S_TITLE     = 2'd0,
    S_RESET     = 2'd1,
    S_PLAY      = 2'd2,
    S_GAME_OVER = 2'd3
  } game_state_e;

  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned SCREEN_H   = 480;
  localparam int unsigned PLAYER_W   = 110;
  localparam int unsigned PLAYER_H   = 20;
  localparam int unsigned BLOCK_W    = 110;
  localparam int unsigned BLOCK_H    = 32;
  localparam int unsigned SCORE_X    = 8;
  localparam int unsigned SCORE_Y    = 8;
  localparam int unsigned SCALE_LOG2 = 2;

  localparam logic [11:0] BG_COLOR     = 12'h000;
  localparam logic [11:0] TITLE_BG     = 12'h004;
  localparam logic [11:0] OVER_BG      = 12'h400;
  localparam logic [11:0] PLAYER_COLOR = 12'h0F0;
  localparam logic [11:0] BLOCK_COLOR  = 12'hF00;
  localparam logic [11:0] SCORE_COLOR  = 12'hFFF;

  // Snapshot of everything the renderer draws from, latched once per frame.
  typedef struct packed {
    logic [9:0]  plx;
    logic [9:0]  ply;
    logic [9:0]  b0x;
    logic [9:0]  b0y;
    logic [9:0]  b1x;
    logic [9:0]  b1y;
    logic [9:0]  b2x;
    logic [9:0]  b2y;
    game_state_e st;
  } shadow_t;

  // p lies in [o, o+len), evaluated at 11 bits so o+len never wraps.
  function automatic logic in_span(input logic [9:0] p, input logic [9:0] o,
                                   input logic [10:0] len);
    logic [10:0] hi;
    hi = {1'b0, o} + len;
    return ({1'b0, p} >= {1'b0, o}) && ({1'b0, p} < hi);
  endfunction

endpackage

// File: rtl/frame_renderer_font.sv
// 3x5 digit font; bits[2] is the leftmost column. Non-decimal codes are blank.
module digit_font_rom (
  input  logic [3:0] digit,
  input  logic [2:0] row,
  output logic [2:0] bits
);

  logic [14:0] glyph;

  // Glyph lookup, then row select (row 0 at the top).
  always_comb begin
    unique case (digit)
      4'd0:    glyph = 15'b111_101_101_101_111;
      4'd1:    glyph = 15'b010_110_010_010_111;
      4'd2:    glyph = 15'b111_001_111_100_111;
      4'd3:    glyph = 15'b111_001_111_001_111;
      4'd4:    glyph = 15'b101_101_111_001_001;
      4'd5:    glyph = 15'b111_100_111_001_111;
      4'd6:    glyph = 15'b111_100_111_101_111;
      4'd7:    glyph = 15'b111_001_001_001_001;
      4'd8:    glyph = 15'b111_101_111_101_111;
      4'd9:    glyph = 15'b111_101_111_001_111;
      default: glyph = '0;
    endcase
    unique case (row)
      3'd0:    bits = glyph[14:12];
      3'd1:    bits = glyph[11:9];
      3'd2:    bits = glyph[8:6];
      3'd3:    bits = glyph[5:3];
      3'd4:    bits = glyph[2:0];
      default: bits = '0;
    endcase
  end

endmodule

// File: rtl/frame_renderer.sv
// Pixel colour generator: per-frame snapshot of game state, sequential
// double-dabble score conversion, and a 2-stage pixel pipeline with syncs
// delayed to match.
module frame_renderer
  import frame_renderer_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  block0_x,
  input  logic [9:0]  block0_y,
  input  logic [9:0]  block1_x,
  input  logic [9:0]  block1_y,
  input  logic [9:0]  block2_x,
  input  logic [9:0]  block2_y,
  input  logic [15:0] score,
  input  logic [1:0]  state,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        bcd_busy
);

  shadow_t     shadow_q, shadow_d;
  logic [15:0] bin_q, bin_d;
  logic [19:0] work_q, work_d;
  logic [3:0]  iter_q, iter_d;
  logic        busy_q, busy_d;
  logic [19:0] digits_q, digits_d;
  logic [4:0]  blink_q, blink_d;
  logic [19:0] adj, shifted;

  logic p_hit_q, p_hit_d, b_hit_q, b_hit_d, glyph_q, glyph_d;
  logic von_q, von_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [11:0] rgb_q, rgb_d;
  logic hs2_q, hs2_d, vs2_q, vs2_d;

  logic [10:0] gx, gy, gdig, grow;
  logic [1:0]  gcol;
  logic [3:0]  font_digit;
  logic [2:0]  font_bits;
  logic        col_bit, in_glyph;

  // Frame snapshot, blink counter and one double-dabble step per busy cycle.
  // A tick always wins, so a tick mid-conversion restarts from the new score.
  always_comb begin
    shadow_d = shadow_q;
    bin_d    = bin_q;
    work_d   = work_q;
    iter_d   = iter_q;
    busy_d   = busy_q;
    digits_d = digits_q;
    blink_d  = blink_q;
    adj      = work_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (adj[4*i +: 4] > 4'd4) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    shifted = (adj << 1) | {19'd0, bin_q[15]};
    if (frame_tick) begin
      shadow_d.plx = player_x;
      shadow_d.ply = player_y;
      shadow_d.b0x = block0_x;
      shadow_d.b0y = block0_y;
      shadow_d.b1x = block1_x;
      shadow_d.b1y = block1_y;
      shadow_d.b2x = block2_x;
      shadow_d.b2y = block2_y;
      shadow_d.st  = game_state_e'(state);
      bin_d        = score;
      work_d       = '0;
      iter_d       = '0;
      busy_d       = 1'b1;
      blink_d      = (game_state_e'(state) == S_GAME_OVER) ? blink_q + 5'd1 : '0;
    end else if (busy_q) begin
      work_d = shifted;
      bin_d  = {bin_q[14:0], 1'b0};
      iter_d = iter_q + 4'd1;
      if (iter_q == 4'd15) begin
        busy_d   = 1'b0;
        digits_d = shifted;
      end
    end
  end

  // Score overlay addressing: digit slot, glyph column and row under the pixel.
  always_comb begin
    gx   = {1'b0, pixel_x} - 11'(SCORE_X);
    gy   = {1'b0, pixel_y} - 11'(SCORE_Y);
    gdig = gx >> (SCALE_LOG2 + 2);
    gcol = gx[SCALE_LOG2 +: 2];
    grow = gy >> SCALE_LOG2;
    unique case (gdig[2:0])
      3'd0:    font_digit = digits_q[19:16];
      3'd1:    font_digit = digits_q[15:12];
      3'd2:    font_digit = digits_q[11:8];
      3'd3:    font_digit = digits_q[7:4];
      3'd4:    font_digit = digits_q[3:0];
      default: font_digit = 4'hF;
    endcase
    unique case (gcol)
      2'd0:    col_bit = font_bits[2];
      2'd1:    col_bit = font_bits[1];
      2'd2:    col_bit = font_bits[0];
      default: col_bit = 1'b0;
    endcase
    in_glyph = (pixel_x >= 10'(SCORE_X)) && (pixel_y >= 10'(SCORE_Y)) &&
               (gdig < 11'd5) && (gcol != 2'd3) && (grow < 11'd5);
  end

  digit_font_rom u_font (
    .digit (font_digit),
    .row   (grow[2:0]),
    .bits  (font_bits)
  );

  // Stage 1: hit flags, glyph bit, and delayed video/sync.
  always_comb begin
    p_hit_d = in_span(pixel_x, shadow_q.plx, 11'(PLAYER_W)) &&
              in_span(pixel_y, shadow_q.ply, 11'(PLAYER_H));
    b_hit_d = ((shadow_q.b0y < 10'(SCREEN_H)) &&
               in_span(pixel_x, shadow_q.b0x, 11'(BLOCK_W)) &&
               in_span(pixel_y, shadow_q.b0y, 11'(BLOCK_H))) ||
              ((shadow_q.b1y < 10'(SCREEN_H)) &&
               in_span(pixel_x, shadow_q.b1x, 11'(BLOCK_W)) &&
               in_span(pixel_y, shadow_q.b1y, 11'(BLOCK_H))) ||
              ((shadow_q.b2y < 10'(SCREEN_H)) &&
               in_span(pixel_x, shadow_q.b2x, 11'(BLOCK_W)) &&
               in_span(pixel_y, shadow_q.b2y, 11'(BLOCK_H)));
    glyph_d = in_glyph && col_bit;
    von_d   = video_on && (pixel_x < 10'(SCREEN_W)) && (pixel_y < 10'(SCREEN_H));
    hs1_d   = hsync_in;
    vs1_d   = vsync_in;
  end

  // Stage 2: colour priority per snapshot state.
  always_comb begin
    rgb_d = '0;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    if (von_q) begin
      unique case (shadow_q.st)
        S_TITLE:     rgb_d = p_hit_q ? PLAYER_COLOR : TITLE_BG;
        S_RESET:     rgb_d = BG_COLOR;
        S_PLAY:      rgb_d = glyph_q ? SCORE_COLOR :
                             p_hit_q ? PLAYER_COLOR :
                             b_hit_q ? BLOCK_COLOR : BG_COLOR;
        S_GAME_OVER: rgb_d = glyph_q ? SCORE_COLOR :
                             (p_hit_q && !blink_q[4]) ? PLAYER_COLOR :
                             b_hit_q ? BLOCK_COLOR : OVER_BG;
        default:     rgb_d = BG_COLOR;
      endcase
    end
  end

  // All state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      bin_q    <= '0;
      work_q   <= '0;
      iter_q   <= '0;
      busy_q   <= 1'b0;
      digits_q <= '0;
      blink_q  <= '0;
      p_hit_q  <= 1'b0;
      b_hit_q  <= 1'b0;
      glyph_q  <= 1'b0;
      von_q    <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      rgb_q    <= '0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      iter_q   <= iter_d;
      busy_q   <= busy_d;
      digits_q <= digits_d;
      blink_q  <= blink_d;
      p_hit_q  <= p_hit_d;
      b_hit_q  <= b_hit_d;
      glyph_q  <= glyph_d;
      von_q    <= von_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      rgb_q    <= rgb_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  assign rgb       = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign bcd_busy  = busy_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Scoreboard bench for frame_renderer: stimulus pushes expected pixel/sync
// values due two cycles later; a monitor pops and compares them.
module tb_frame_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_tick;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [9:0]  player_x, player_y;
  logic [9:0]  block0_x, block0_y, block1_x, block1_y, block2_x, block2_y;
  logic [15:0] score;
  logic [1:0]  state;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out, bcd_busy;

  frame_renderer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .player_x   (player_x),
    .player_y   (player_y),
    .block0_x   (block0_x),
    .block0_y   (block0_y),
    .block1_x   (block1_x),
    .block1_y   (block1_y),
    .block2_x   (block2_x),
    .block2_y   (block2_y),
    .score      (score),
    .state      (state),
    .rgb        (rgb),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .bcd_busy   (bcd_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   cyc = 0;
  int   vecs = 0;
  int   miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the head of the scoreboard when its cycle comes due.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (sb[0].due < cyc) begin
        m_e = sb.pop_front();
        vecs++;
        miss++;
        $display("FAIL %s: output slot at cycle %0d was never sampled", m_e.tag, m_e.due);
      end else if (sb[0].due == cyc) begin
        m_e = sb.pop_front();
        vecs++;
        if (rgb !== m_e.rgb || hsync_out !== m_e.hs || vsync_out !== m_e.vs) begin
          miss++;
          $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                   m_e.tag, rgb, hsync_out, vsync_out, m_e.rgb, m_e.hs, m_e.vs);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One pixel per cycle, random syncs; expected output due two edges later.
  task automatic apply(input int x, input int y, input logic von,
                       input logic [11:0] exp, input string tag);
    logic h, v;
    h = 1'($urandom_range(0, 1));
    v = 1'($urandom_range(0, 1));
    @(negedge clk);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    hsync_in = h;
    vsync_in = v;
    sb.push_back('{due: cyc + 2, rgb: exp, hs: h, vs: v, tag: tag});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      vecs++;
      miss++;
      $display("FAIL drain: %0d expected outputs never checked", sb.size());
      sb.delete();
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the tick edge.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic busy_len(input string tag);
    int n = 0;
    while (bcd_busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'd16);
  endtask

  function automatic logic [14:0] font(input logic [3:0] d);
    case (d)
      4'd0:    return 15'b111_101_101_101_111;
      4'd1:    return 15'b010_110_010_010_111;
      4'd2:    return 15'b111_001_111_100_111;
      4'd3:    return 15'b111_001_111_001_111;
      4'd4:    return 15'b101_101_111_001_001;
      4'd5:    return 15'b111_100_111_001_111;
      4'd6:    return 15'b111_100_111_101_111;
      4'd7:    return 15'b111_001_001_001_001;
      4'd8:    return 15'b111_101_111_101_111;
      4'd9:    return 15'b111_101_111_001_111;
      default: return '0;
    endcase
  endfunction

  // Sweep every glyph cell (plus the gap column) of all five digits.
  task automatic check_digits(input logic [19:0] bcd, input string tag);
    logic [3:0]  dg;
    logic [14:0] g;
    logic [11:0] e;
    for (int d = 0; d < 5; d++) begin
      dg = bcd[4*(4-d) +: 4];
      g  = font(dg);
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          e = (c < 3 && g[14 - 3*r - c]) ? 12'hFFF : 12'h000;
          apply(8 + 16*d + 4*c + 1, 8 + 4*r + 2, 1'b1, e,
                $sformatf("%s_d%0d_r%0d_c%0d", tag, d, r, c));
        end
      end
    end
    apply(8 + 80 + 1, 10, 1'b1, 12'h000, {tag, "_past_digit4"});
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    frame_tick = 1'b0;
    pixel_x    = '0;
    pixel_y    = '0;
    video_on   = 1'b1;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    player_x   = 10'd600;
    player_y   = 10'd0;
    block0_x   = 10'd0;
    block0_y   = 10'd500;
    block1_x   = 10'd0;
    block1_y   = 10'd500;
    block2_x   = 10'd0;
    block2_y   = 10'd500;
    score      = 16'd12345;
    state      = 2'd2;
    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(rgb), 32'h000);
    check("reset_hsync", 32'(hsync_out), 32'd1);
    check("reset_vsync", 32'(vsync_out), 32'd1);
    check("reset_busy", 32'(bcd_busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // BCD conversion of 12345, then hold with a new score and no tick.
    tick();
    busy_len("bcd_busy_12345");
    check_digits(20'h12345, "bcd12345");
    score = 16'd9;
    check_digits(20'h12345, "hold12345");

    // Restart: a second tick in busy cycle 5 restarts with the new score.
    score = 16'd54321;
    tick();
    repeat (4) @(negedge clk);
    check("busy_cycle5", 32'(bcd_busy), 32'd1);
    score = 16'd777;
    tick();
    busy_len("bcd_busy_restart");
    check_digits(20'h00777, "bcd777");

    // Score 0 glyph corners and video blanking.
    score = 16'd0;
    tick();
    repeat (17) @(negedge clk);
    apply(8, 8, 1'b1, 12'hFFF, "glyph_8_8");
    apply(12, 28, 1'b1, 12'h000, "glyph_12_28");
    apply(12, 12, 1'b1, 12'h000, "glyph_row1_centre");
    apply(8, 12, 1'b1, 12'hFFF, "glyph_row1_left");
    apply(8, 8, 1'b0, 12'h000, "video_off");
    drain();

    // Player edges; input moves after the tick must not show.
    player_x = 10'd265;
    player_y = 10'd440;
    tick();
    player_x = 10'd0;
    apply(300, 450, 1'b1, 12'h0F0, "player_inside");
    apply(374, 459, 1'b1, 12'h0F0, "player_br_corner");
    apply(375, 450, 1'b1, 12'h000, "player_right_excl");
    apply(264, 450, 1'b1, 12'h000, "player_left_excl");
    apply(300, 460, 1'b1, 12'h000, "player_bottom_excl");
    apply(265, 440, 1'b1, 12'h0F0, "player_tl_corner");
    apply(10, 450, 1'b1, 12'h000, "snapshot_ignores_move");
    drain();
    player_x = 10'd265;

    // Priority and clipping.
    block0_x = 10'd265;
    block0_y = 10'd440;
    block1_x = 10'd0;
    block1_y = 10'd470;
    block2_x = 10'd400;
    block2_y = 10'd500;
    tick();
    apply(300, 450, 1'b1, 12'h0F0, "player_over_block");
    apply(300, 465, 1'b1, 12'hF00, "block0_below_player");
    apply(50, 479, 1'b1, 12'hF00, "block1_clipped");
    apply(0, 479, 1'b1, 12'hF00, "block1_left_edge");
    apply(109, 479, 1'b1, 12'hF00, "block1_right_edge");
    apply(110, 479, 1'b1, 12'h000, "block1_right_excl");
    apply(50, 469, 1'b1, 12'h000, "block1_above");
    apply(450, 479, 1'b1, 12'h000, "block2_offscreen");
    apply(400, 0, 1'b1, 12'h000, "block2_wrap");
    drain();

    // Game over: blink period of 32 ticks.
    block0_y = 10'd500;
    state    = 2'd3;
    for (int k = 1; k <= 33; k++) begin
      tick();
      apply(300, 450, 1'b1, ((k % 32) < 16) ? 12'h0F0 : 12'h400,
            $sformatf("blink_tick%0d", k));
      apply(0, 0, 1'b1, 12'h400, $sformatf("over_bg_tick%0d", k));
      drain();
    end

    // Title: player only on TITLE_BG.
    state = 2'd0;
    tick();
    apply(300, 450, 1'b1, 12'h0F0, "title_player");
    apply(50, 479, 1'b1, 12'h004, "title_no_block");
    apply(8, 8, 1'b1, 12'h004, "title_no_score");
    drain();

    // Reset state: plain background.
    state = 2'd1;
    tick();
    apply(300, 450, 1'b1, 12'h000, "rstate_no_player");
    apply(50, 479, 1'b1, 12'h000, "rstate_no_block");
    apply(8, 8, 1'b1, 12'h000, "rstate_no_score");
    drain();

    // Asynchronous reset mid-frame while busy and drawing.
    state = 2'd2;
    tick();
    pixel_x  = 10'd300;
    pixel_y  = 10'd450;
    video_on = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_rgb", 32'(rgb), 32'h0F0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_rgb", 32'(rgb), 32'h000);
    check("async_reset_hsync", 32'(hsync_out), 32'd1);
    check("async_reset_vsync", 32'(vsync_out), 32'd1);
    check("async_reset_busy", 32'(bcd_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
